// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer_pkg
// Purpose  : Shared state encoding and default word width for the serializer.
//            The width constant is also used by the upstream parallel
//            register stage.
// Revision : 1.0 - initial release
// ============================================================================
package piso_serializer_pkg;

  // Default word width, shared with the parallel register stage.
  localparam int DEFAULT_WIDTH = 4;

  // Serializer FSM encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : piso_serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-MODULUS up counter with synchronous clear-to-zero,
//            count enable and a terminal-count flag (cnt == MODULUS-1).
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter
  import piso_serializer_pkg::*;
#(
  parameter int MODULUS = DEFAULT_WIDTH,
  parameter int CNT_W   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over enable; wrap after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_W'(MODULUS - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_W'(MODULUS - 1));

endmodule : mod_counter
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in serial-out converter with valid/ready word intake,
//            registered serial bit, frame-start and done markers. Words can
//            stream back-to-back with no idle cycle between them.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  // The shift register is cleared whenever no word is in flight, so its
  // outgoing end doubles as the registered serial output (0 when idle).
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             accept;
  logic             in_shift;
  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Bit order selection: which end leaves first and which way the word moves.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign out_bit      = sreg_q[WIDTH-1];
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit      = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign in_shift = (state_q == ST_SHIFT);
  assign in_ready = !reset && ((state_q == ST_IDLE) || (in_shift && cnt_tc));
  assign accept   = in_valid && in_ready;

  // Counter tracks the index of the bit currently presented; it restarts on
  // every load and whenever the last bit of a word has been presented.
  assign cnt_clr = accept || (in_shift && cnt_tc);
  assign cnt_en  = in_shift && !cnt_tc;

  mod_counter #(
    .MODULUS (WIDTH),
    .CNT_W   (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // Next-state and next-output logic: load on accept, shift while mid-word,
  // fall back to idle with cleared outputs after the last bit.
  always_comb begin
    state_d        = state_q;
    sreg_d         = sreg_q;
    serial_valid_d = serial_valid_q;
    frame_start_d  = 1'b0;
    done_d         = 1'b0;
    if (accept) begin
      state_d        = ST_SHIFT;
      sreg_d         = parallel_in;
      serial_valid_d = 1'b1;
      frame_start_d  = 1'b1;
    end else if (in_shift) begin
      if (cnt_tc) begin
        state_d        = ST_IDLE;
        sreg_d         = '0;
        serial_valid_d = 1'b0;
      end else begin
        sreg_d         = sreg_shifted;
        serial_valid_d = 1'b1;
        done_d         = (cnt == CNT_W'(WIDTH - 2));
      end
    end
  end

  // State and output registers with synchronous reset; reset aborts a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sreg_q         <= '0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sreg_q         <= sreg_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      done_q         <= done_d;
    end
  end

  assign serial_out   = out_bit;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign done         = done_q;

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for piso_serializer. Two instances (MSB-first
//            and LSB-first) share one stimulus stream; a word-level model
//            pushes expected bits on every accept and a negedge monitor pops
//            and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] parallel_in = '0;

  logic m_ready, m_out, m_valid, m_fs, m_done;
  logic l_ready, l_out, l_valid, l_fs, l_done;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
    .clk          (clk),
    .reset        (reset),
    .parallel_in  (parallel_in),
    .in_valid     (in_valid),
    .in_ready     (m_ready),
    .serial_out   (m_out),
    .serial_valid (m_valid),
    .frame_start  (m_fs),
    .done         (m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
    .clk          (clk),
    .reset        (reset),
    .parallel_in  (parallel_in),
    .in_valid     (in_valid),
    .in_ready     (l_ready),
    .serial_out   (l_out),
    .serial_valid (l_valid),
    .frame_start  (l_fs),
    .done         (l_done)
  );

  typedef struct {
    logic b_msb;
    logic b_lsb;
    logic fs;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  int   left   = 0;   // bit slots of the current word still to be shown
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from the word-level
  // rule "ready when idle or on the last bit" and queues the expected bits.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic ready_m;
    in_valid    = v;
    parallel_in = d;
    reset       = r;
    ready_m     = !r && (left <= 1);
    @(posedge clk);
    if (r) begin
      left = 0;
      exp_q.delete();
    end else if (v && ready_m) begin
      left = W;
      for (int i = 0; i < W; i++) begin
        exp_t e;
        e.b_msb = d[W-1-i];
        e.b_lsb = d[i];
        e.fs    = (i == 0);
        e.dn    = (i == W - 1);
        exp_q.push_back(e);
      end
    end else if (left > 0) begin
      left--;
    end
    #1;
  endtask

  // Monitor: compare both instances against the queue head every cycle.
  initial begin
    @(posedge clk);
    forever begin
      exp_t e;
      logic ev;
      logic rdy;
      @(negedge clk);
      ev  = (exp_q.size() > 0);
      rdy = !reset && (left <= 1);
      if (ev) e = exp_q[0];
      else    e = '{1'b0, 1'b0, 1'b0, 1'b0};
      chk("msb_in_ready",     m_ready, rdy);
      chk("msb_serial_valid", m_valid, ev);
      chk("msb_serial_out",   m_out,   e.b_msb);
      chk("msb_frame_start",  m_fs,    e.fs);
      chk("msb_done",         m_done,  e.dn);
      chk("lsb_in_ready",     l_ready, rdy);
      chk("lsb_serial_valid", l_valid, ev);
      chk("lsb_serial_out",   l_out,   e.b_lsb);
      chk("lsb_frame_start",  l_fs,    e.fs);
      chk("lsb_done",         l_done,  e.dn);
      if (ev) void'(exp_q.pop_front());
    end
  end

  initial begin
    // Reset state.
    repeat (3) step(1'b1, 4'b1111, 1'b1);
    repeat (2) step(1'b0, 4'b0000, 1'b0);

    // Single word from idle.
    step(1'b1, 4'b1011, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // Back-to-back: second word presented on the first word's last bit.
    step(1'b1, 4'b1011, 1'b0);
    repeat (3) step(1'b1, 4'b1011, 1'b0);
    step(1'b1, 4'b1100, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // Offer during shift is held off until the last bit.
    step(1'b1, 4'b1100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    repeat (3) step(1'b1, 4'b0011, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // Reset mid-frame, then a fresh word.
    step(1'b1, 4'b1100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0110, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // Idle gap between words.
    step(1'b1, 4'b1011, 1'b0);
    repeat (6) step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b0101, 1'b0);
    repeat (5) step(1'b0, 4'b0000, 1'b0);

    // Randomized traffic with occasional resets and churning data.
    repeat (500) begin
      step(($urandom_range(0, 9) < 7),
           W'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 3));
    end
    repeat (6) step(1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_piso_serializer
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out converter that takes the registered word produced by the team's 4-bit parallel register stage and emits it one bit per clock. It sits directly downstream of that register: `parallel_in` is driven by the register's `parallel_out`, and a valid/ready handshake controls word transfer. The serial output includes frame-start and done markers so a downstream receiver or UART-style framer can delimit words. Back-to-back words stream with no idle bubble.

## Interface
- `WIDTH`, default 4: word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit `WIDTH-1` is sent first; 0 = bit 0 is sent first.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `parallel_in`, input, WIDTH: word to serialize; sampled only on an accept edge.
- `in_valid`, input, 1: upstream offers `parallel_in`.
- `in_ready`, output, 1: block can accept a word this cycle; combinational from state.
- `serial_out`, output, 1: current serial bit; registered.
- `serial_valid`, output, 1: `serial_out` carries a data bit; registered.
- `frame_start`, output, 1: high during the first bit of each word; registered.
- `done`, output, 1: high during the last bit of each word; registered.

## Operation
- **Two states:** IDLE and SHIFT. Internal state is a WIDTH-bit shift register and a bit counter `cnt` of width clog2(WIDTH) (0..WIDTH-1).
- **Accept:** an accept occurs on an edge where `in_valid && in_ready`.
- **`in_ready`:** equals `!reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`.
- **IDLE:**
  - `serial_valid`, `frame_start`, `done` and `serial_out` are 0.
  - On accept: load the shift register, set `cnt` to 0, go to SHIFT, and drive the first bit with `frame_start` set to 1.
- **SHIFT:** on each edge, advance `cnt` and present the next bit (MSB-first shifts left; LSB-first shifts right).
  - `done` is 1 exactly when the presented bit is bit index WIDTH-1 of the sequence.
  - If `cnt==WIDTH-1` and an accept occurs, load the new word and stay in SHIFT with `cnt` set to 0 and `frame_start` set to 1. This gives a continuous stream.
  - If `cnt==WIDTH-1` and there is no accept, return to IDLE and clear all outputs.
- **Ignored offers:** `in_valid` during SHIFT with `cnt<WIDTH-1` is ignored. Upstream must hold the word until `in_ready` is high.
- **Reset:** while `reset` is high, all outputs are 0 and `in_ready` is 0. State returns to IDLE and `cnt` to 0.
  - A reset mid-frame aborts the word: no `done` pulse, and the remaining bits are discarded.
  - `in_valid` is ignored while reset is high.
- **`parallel_in` changes:** changes outside an accept edge have no effect.

## Timing
- Accept at edge k: the first bit is visible after edge k. Bit i is visible in cycle k+i, for i = 0..WIDTH-1.
- A word occupies exactly WIDTH cycles with `serial_valid` high.
- In a back-to-back stream, the next word's first bit follows the previous word's last bit in the next cycle, with zero gap.
- `frame_start` and `done` are each high for exactly one cycle per word. With WIDTH ≥ 2 they never coincide.
- Reset value of every output is 0, and `in_ready` is 0 while `reset` is high. `in_ready` becomes 1 in the first cycle after reset deasserts.

## Structure
- **Shared package/header:** holds the state encoding localparams (`ST_IDLE`=0, `ST_SHIFT`=1) and the default width constant, which is shared with the parallel register stage.
- **Sub-module:** one natural sub-module, `mod_counter`, a mod-WIDTH counter with load-zero, enable and terminal-count outputs. The shift register and FSM stay in `piso_serializer`.

## Test plan
- **Single word, MSB-first:** WIDTH=4, MSB_FIRST=1. Offer 4'b1011 for one cycle from IDLE.
  - `serial_out` = 1,0,1,1 over 4 cycles with `serial_valid` high.
  - `frame_start` is high in cycle 1 and `done` in cycle 4; all outputs are 0 afterwards.
- **Back-to-back:** hold `in_valid` high with 4'b1011, then 4'b1100 presented on the first word's last cycle.
  - Eight contiguous valid bits: 1,0,1,1,1,1,0,0.
  - `frame_start` is high in cycles 1 and 5; `done` in cycles 4 and 8.
- **LSB-first:** MSB_FIRST=0. Offer 4'b1011.
  - `serial_out` = 1,1,0,1.
- **Offer during shift:** while sending 4'b1100, assert `in_valid` with 4'b0011 at bit 2.
  - `in_ready` stays 0 until bit 4.
  - 0011 is accepted at the end of bit 4, then emitted as 0,0,1,1.
- **Reset mid-frame:** assert `reset` after 2 bits of 4'b1100.
  - All outputs are 0 on the next cycle and no `done` pulse occurs.
  - `in_ready` returns to 1 in the first cycle after `reset` deasserts, and a fresh 4'b0110 then serializes as 0,1,1,0.
- **Idle gap:** `in_valid` low for 3 cycles between words.
  - `serial_valid`, `serial_out`, `frame_start` and `done` stay 0 throughout the gap.
